// File: rtl/reg_file_rename.sv
// Architectural register file with a per-register rename tag table.
// Committed results are written back from the ROB. Dispatcher renames record
// the owning ROB tag. Operand reads forward a matching same-cycle commit.
module reg_file_rename #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned TAG_W    = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             commit_valid,
    input  logic [4:0]       commit_rd,
    input  logic [XLEN-1:0]  commit_res,
    input  logic [TAG_W-1:0] commit_dependency,
    input  logic             rename_valid,
    input  logic [4:0]       rename_rd,
    input  logic [TAG_W-1:0] rename_tag,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [XLEN-1:0]  rs1_value,
    output logic [XLEN-1:0]  rs2_value,
    output logic [TAG_W-1:0] rs1_tag,
    output logic [TAG_W-1:0] rs2_tag
);

    logic [XLEN-1:0]  r_value [NUM_REGS];
    logic [TAG_W-1:0] r_tag   [NUM_REGS];

    logic w_commit_en;
    logic w_rename_en;
    logic w_bypass1;
    logic w_bypass2;

    // x0 is never written, so its entries stay at their reset value of zero.
    assign w_commit_en = commit_valid && (commit_rd != '0);
    assign w_rename_en = rename_valid && (rename_rd != '0) && !flush;

    assign w_bypass1 = commit_valid && (commit_rd == rs1_addr) &&
                       (commit_dependency == r_tag[rs1_addr]);
    assign w_bypass2 = commit_valid && (commit_rd == rs2_addr) &&
                       (commit_dependency == r_tag[rs2_addr]);

    // State update: commit write, then tag clear on flush or rename ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
        end else if (rdy) begin
            if (w_commit_en) begin
                r_value[commit_rd] <= commit_res;
                // A younger rename keeps ownership when the tags differ.
                if (r_tag[commit_rd] == commit_dependency) begin
                    r_tag[commit_rd] <= '0;
                end
            end
            // Later assignments win: flush clears everything, and a rename
            // overrides the commit's tag clear on the same register.
            if (flush) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    r_tag[i] <= '0;
                end
            end else if (w_rename_en) begin
                r_tag[rename_rd] <= rename_tag;
            end
        end
    end

    // Operand 1 read: ready value, forwarded commit, or pending tag.
    always_comb begin
        rs1_value = '0;
        rs1_tag   = '0;
        if (rs1_addr != '0) begin
            if (r_tag[rs1_addr] == '0) begin
                rs1_value = r_value[rs1_addr];
            end else if (w_bypass1) begin
                rs1_value = commit_res;
            end else begin
                rs1_value = r_value[rs1_addr];
                rs1_tag   = r_tag[rs1_addr];
            end
        end
    end

    // Operand 2 read: ready value, forwarded commit, or pending tag.
    always_comb begin
        rs2_value = '0;
        rs2_tag   = '0;
        if (rs2_addr != '0) begin
            if (r_tag[rs2_addr] == '0) begin
                rs2_value = r_value[rs2_addr];
            end else if (w_bypass2) begin
                rs2_value = commit_res;
            end else begin
                rs2_value = r_value[rs2_addr];
                rs2_tag   = r_tag[rs2_addr];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_rename.sv
// Self-checking bench for reg_file_rename: directed scenarios followed by
// randomized traffic, all compared against a behavioural array model.
module tb_reg_file_rename;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_res;
    logic [4:0]  commit_dependency;
    logic        rename_valid;
    logic [4:0]  rename_rd;
    logic [4:0]  rename_tag;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [4:0]  rs1_tag;
    logic [4:0]  rs2_tag;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: committed value and pending tag per register.
    logic [31:0] m_val [32];
    logic [4:0]  m_tag [32];

    reg_file_rename #(
        .XLEN     (32),
        .TAG_W    (5),
        .NUM_REGS (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .flush             (flush),
        .commit_valid      (commit_valid),
        .commit_rd         (commit_rd),
        .commit_res        (commit_res),
        .commit_dependency (commit_dependency),
        .rename_valid      (rename_valid),
        .rename_rd         (rename_rd),
        .rename_tag        (rename_tag),
        .rs1_addr          (rs1_addr),
        .rs2_addr          (rs2_addr),
        .rs1_value         (rs1_value),
        .rs2_value         (rs2_value),
        .rs1_tag           (rs1_tag),
        .rs2_tag           (rs2_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Expected operand read for address a given the model and current inputs.
    task automatic model_read(input logic [4:0] a, output logic [31:0] v, output logic [4:0] t,
                              output bit v_known);
        v = '0; t = '0; v_known = 1'b1;
        if (a == 0) begin
            v = 0; t = 0;
        end else if (m_tag[a] == 0) begin
            v = m_val[a]; t = 0;
        end else if (commit_valid && commit_rd == a && commit_dependency == m_tag[a]) begin
            v = commit_res; t = 0;
        end else begin
            t = m_tag[a]; v_known = 1'b0;
        end
    endtask

    // Apply the register-file rules for one clock edge using the held inputs.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = 0;
                m_tag[i] = 0;
            end
        end else if (rdy) begin
            if (commit_valid && commit_rd != 0) begin
                m_val[commit_rd] = commit_res;
                if (m_tag[commit_rd] == commit_dependency) m_tag[commit_rd] = 0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) m_tag[i] = 0;
            end else if (rename_valid && rename_rd != 0) begin
                m_tag[rename_rd] = rename_tag;
            end
        end
    endtask

    task automatic idle();
        rst = 0; rdy = 1; flush = 0;
        commit_valid = 0; commit_rd = 0; commit_res = 0; commit_dependency = 0;
        rename_valid = 0; rename_rd = 0; rename_tag = 0;
    endtask

    // Inputs are already driven: compare reads, clock once, update model.
    task automatic step();
        logic [31:0] ev;
        logic [4:0]  et;
        bit          known;
        #1;
        model_read(rs1_addr, ev, et, known);
        check("rs1_tag", {59'd0, rs1_tag}, {59'd0, et});
        if (known) check("rs1_value", {32'd0, rs1_value}, {32'd0, ev});
        model_read(rs2_addr, ev, et, known);
        check("rs2_tag", {59'd0, rs2_tag}, {59'd0, et});
        if (known) check("rs2_value", {32'd0, rs2_value}, {32'd0, ev});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [4:0] tg);
        idle();
        rename_valid = 1; rename_rd = rd; rename_tag = tg;
        rs1_addr = rd; rs2_addr = 0;
        step();
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [4:0] dep, input logic [31:0] res);
        idle();
        commit_valid = 1; commit_rd = rd; commit_dependency = dep; commit_res = res;
        rs1_addr = rd; rs2_addr = 0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_val[i] = 'x;
            m_tag[i] = 'x;
        end
        idle();
        rs1_addr = 0; rs2_addr = 0;
        rst = 1;
        @(posedge clk);
        model_edge();
        #1;
        idle();

        // 1: reset state reads zero
        rs1_addr = 5; rs2_addr = 0;
        #1;
        check("t1_rs1_value", {32'd0, rs1_value}, 64'd0);
        check("t1_rs1_tag", {59'd0, rs1_tag}, 64'd0);
        check("t1_rs2_tag", {59'd0, rs2_tag}, 64'd0);
        step();

        // 2: rename, pending tag, commit bypass, then value from state
        do_rename(5, 3);
        idle(); rs1_addr = 5; rs2_addr = 5;
        #1;
        check("t2_pending_tag", {59'd0, rs1_tag}, 64'd3);
        step();
        idle();
        commit_valid = 1; commit_rd = 5; commit_dependency = 3; commit_res = 32'hDEADBEEF;
        rs1_addr = 5; rs2_addr = 5;
        #1;
        check("t2_bypass_value", {32'd0, rs1_value}, 64'hDEADBEEF);
        check("t2_bypass_tag", {59'd0, rs1_tag}, 64'd0);
        step();
        idle(); rs1_addr = 5; rs2_addr = 0;
        #1;
        check("t2_state_value", {32'd0, rs1_value}, 64'hDEADBEEF);
        step();

        // 3: stale commit keeps younger tag
        do_rename(7, 2);
        do_rename(7, 4);
        do_commit(7, 2, 32'h11);
        idle(); rs1_addr = 7; rs2_addr = 0;
        #1;
        check("t3_tag_kept", {59'd0, rs1_tag}, 64'd4);
        step();
        do_commit(7, 4, 32'h22);
        idle(); rs1_addr = 7; rs2_addr = 7;
        #1;
        check("t3_value", {32'd0, rs2_value}, 64'h22);
        check("t3_tag_clear", {59'd0, rs2_tag}, 64'd0);
        step();

        // 4: same-cycle commit and rename, rename wins the tag
        do_rename(9, 6);
        idle();
        commit_valid = 1; commit_rd = 9; commit_dependency = 6; commit_res = 32'h99;
        rename_valid = 1; rename_rd = 9; rename_tag = 8;
        rs1_addr = 9; rs2_addr = 0;
        step();
        idle(); rs1_addr = 9; rs2_addr = 0;
        #1;
        check("t4_tag", {59'd0, rs1_tag}, 64'd8);
        step();

        // 5: flush applies commit, clears tags, drops rename
        do_rename(1, 1);
        do_rename(2, 2);
        do_rename(3, 3);
        idle();
        flush = 1;
        commit_valid = 1; commit_rd = 1; commit_dependency = 1; commit_res = 32'h40;
        rename_valid = 1; rename_rd = 4; rename_tag = 5;
        rs1_addr = 2; rs2_addr = 3;
        step();
        idle(); rs1_addr = 1; rs2_addr = 4;
        #1;
        check("t5_x1_value", {32'd0, rs1_value}, 64'h40);
        check("t5_x1_tag", {59'd0, rs1_tag}, 64'd0);
        check("t5_x4_tag", {59'd0, rs2_tag}, 64'd0);
        step();
        idle(); rs1_addr = 2; rs2_addr = 3;
        #1;
        check("t5_x2_tag", {59'd0, rs1_tag}, 64'd0);
        check("t5_x3_tag", {59'd0, rs2_tag}, 64'd0);
        step();

        // 6: x0 writes dropped, rdy=0 holds, rst clears pending tags
        do_rename(0, 5);
        do_commit(0, 0, 32'hFF);
        idle(); rs1_addr = 0; rs2_addr = 0;
        #1;
        check("t6_x0_value", {32'd0, rs1_value}, 64'd0);
        check("t6_x0_tag", {59'd0, rs1_tag}, 64'd0);
        step();
        idle(); rdy = 0;
        rename_valid = 1; rename_rd = 6; rename_tag = 7;
        commit_valid = 1; commit_rd = 6; commit_res = 32'h1234; commit_dependency = 0;
        rs1_addr = 6; rs2_addr = 0;
        step();
        idle(); rs1_addr = 6; rs2_addr = 0;
        #1;
        check("t6_rdy_hold_tag", {59'd0, rs1_tag}, 64'd0);
        check("t6_rdy_hold_value", {32'd0, rs1_value}, 64'd0);
        step();
        do_rename(10, 11);
        idle(); rst = 1; rdy = 0; rs1_addr = 10; rs2_addr = 9;
        step();
        idle(); rs1_addr = 10; rs2_addr = 9;
        #1;
        check("t6_rst_tag10", {59'd0, rs1_tag}, 64'd0);
        check("t6_rst_value9", {32'd0, rs2_value}, 64'd0);
        step();

        // Randomized traffic on a narrow register window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] crd;
            idle();
            rst   = ($urandom_range(0, 199) == 0);
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 29) == 0);
            commit_valid = $urandom_range(0, 1);
            crd = 5'($urandom_range(0, 7));
            commit_rd  = crd;
            commit_res = $urandom;
            if ($urandom_range(0, 1) == 1) commit_dependency = m_tag[crd];
            else commit_dependency = 5'($urandom_range(0, 31));
            rename_valid = $urandom_range(0, 1);
            rename_rd    = 5'($urandom_range(0, 7));
            rename_tag   = 5'($urandom_range(1, 31));
            rs1_addr = ($urandom_range(0, 1) == 1) ? crd : 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 8));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
